// File: rtl/serial_rx.sv
// serial_rx: frame receiver for the idle-high serial link.
// Frame = start bit (0), DATA_W data bits LSB first, stop bit (1); each bit
// lasts BIT_CYCLES clocks and is sampled H = (BIT_CYCLES-1)/2 clocks into it.
// Received words are held on a valid/ready port; a bad stop bit raises a
// one-cycle framing-error pulse, and a good word that finds the output still
// occupied is dropped with a one-cycle overrun pulse.
module serial_rx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy_out,
  output logic              frame_err_out,
  output logic              overrun_out
);

  // Sample offset inside each bit period.
  localparam int HALF  = (BIT_CYCLES - 1) / 2;
  localparam int CYC_W = $clog2(BIT_CYCLES + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  // Cycle-counter value at which a data or stop bit is sampled: the counter
  // restarts on each state entry, which is aligned so that the last cycle of
  // every bit period lands exactly on the sample point.
  localparam logic [CYC_W-1:0] LAST_CYC    = CYC_W'(BIT_CYCLES - 1);
  // Start confirmation happens HALF cycles after detection; S_START is
  // entered one cycle after detection, hence the minus one.
  localparam logic [CYC_W-1:0] CONFIRM_CYC = CYC_W'((HALF == 0) ? 0 : HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [CYC_W-1:0]   cyc_cnt_q,   cyc_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0]  shift_q,     shift_d;
  logic [DATA_W-1:0]  data_q,      data_d;
  logic               valid_q,     valid_d;
  logic               busy_q,      busy_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q,   overrun_d;

  // Next-state, datapath and flag computation for the receive FSM.
  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = '0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // A handshake empties the output register unless a new word loads below.
    valid_d     = valid_q & ~ready_in;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!serial) begin
          // With no sampling offset the start is confirmed on the detection
          // cycle itself, so the start state is skipped entirely.
          if (HALF == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_START;
          end
        end
      end

      S_START: begin
        if (cyc_cnt_q == CONFIRM_CYC) begin
          // Line back high at the confirm point: treat as a glitch.
          state_d   = serial ? S_IDLE : S_DATA;
          bit_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cyc_cnt_q == LAST_CYC) begin
          // LSB arrives first, so shift right and insert at the top.
          shift_d             = shift_q >> 1;
          shift_d[DATA_W-1]   = serial;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cyc_cnt_q == LAST_CYC) begin
          if (serial) begin
            state_d = S_IDLE;
            // Load when the slot is free or is being emptied this cycle.
            if (!valid_q || ready_in) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            // Bad stop bit: drop the word and wait for the line to recover.
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        bit_cnt_d = '0;
        if (serial) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cyc_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign busy_out      = busy_q;
  assign frame_err_out = frame_err_q;
  assign overrun_out   = overrun_q;

endmodule
